// File: rtl/tetris_field_engine.sv
// -----------------------------------------------------------------------------
// tetris_field_engine
//
// Playfield storage and update engine. It owns the colour field, answers
// collision queries for a 4x4 block mask, appends blocks into the field, and
// then removes every full row, one row per clock, reporting how many rows
// were removed.
//
// Optional feature macro: TETRIS_FIELD_GARBAGE_ROW_EN
//   defined   : op 3 (GARBAGE) pushes the field up one row and inserts a
//               garbage row with a single hole at the bottom.
//   undefined : op 3 is a no-op that still produces an all-zero response.
//
// Ports
//   clk_i          clock
//   srst_n_i       synchronous active-low reset
//   cmd_valid_i    command request
//   cmd_ready_o    high only while idle; accept = valid && ready
//   cmd_op_i       0=CLEAR 1=CHECK 2=APPEND 3=GARBAGE
//   blk_mask_i     4x4 mask, bit[4*i+j] = block row i, block column j
//   blk_x_i        signed column of the mask origin
//   blk_y_i        signed row of the mask origin
//   blk_color_i    colour used by APPEND (0 is written as 1)
//   resp_valid_o   one-cycle response strobe
//   resp_collide_o CHECK result
//   resp_lines_o   rows removed by APPEND (0..4)
//   resp_topout_o  something ended up above / in the top row
//   field_o        registered field, cell (r,c) at [(r*COLS+c)*COLOR_W +: COLOR_W]
// -----------------------------------------------------------------------------
module tetris_field_engine #(
    parameter int ROWS          = 20,
    parameter int COLS          = 10,
    parameter int COLOR_W       = 3,
    parameter int GARBAGE_COLOR = 7,
    localparam int XW           = $clog2(COLS) + 2,
    localparam int YW           = $clog2(ROWS) + 2
) (
    input  logic                          clk_i,
    input  logic                          srst_n_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [1:0]                    cmd_op_i,
    input  logic [15:0]                   blk_mask_i,
    input  logic [XW-1:0]                 blk_x_i,
    input  logic [YW-1:0]                 blk_y_i,
    input  logic [COLOR_W-1:0]            blk_color_i,
    output logic                          resp_valid_o,
    output logic                          resp_collide_o,
    output logic [2:0]                    resp_lines_o,
    output logic                          resp_topout_o,
    output logic [ROWS*COLS*COLOR_W-1:0]  field_o
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

`ifdef TETRIS_FIELD_GARBAGE_ROW_EN
    localparam bit GARB_EN = 1'b1;
`else
    localparam bit GARB_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        CHECK  = 3'd2,
        APPEND = 3'd3,
        SCAN   = 3'd4,
        GARB   = 3'd5,
        RESP   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_reg, state_next;
    logic [COLOR_W-1:0]   field_reg  [ROWS][COLS];
    logic [COLOR_W-1:0]   field_next [ROWS][COLS];

    logic [15:0]          cmd_mask_reg;
    logic [XW-1:0]        cmd_x_reg;
    logic [YW-1:0]        cmd_y_reg;
    logic [COLOR_W-1:0]   cmd_color_reg;

    logic [2:0]           lines_reg, lines_next;
    logic                 topout_acc_reg, topout_acc_next;

    logic                 resp_collide_reg, resp_collide_next;
    logic [2:0]           resp_lines_reg, resp_lines_next;
    logic                 resp_topout_reg, resp_topout_next;

    logic                 cmd_accept;

    assign cmd_ready_o    = (state_reg == IDLE);
    assign cmd_accept     = cmd_valid_i && cmd_ready_o;
    assign resp_valid_o   = (state_reg == RESP);
    assign resp_collide_o = resp_collide_reg;
    assign resp_lines_o   = resp_lines_reg;
    assign resp_topout_o  = resp_topout_reg;

    // ------------------------------------------------------------------
    // Per mask cell: mapped coordinates, range tests, collision, writes.
    // Coordinates are carried one bit wider than the inputs so that
    // origin + 3 never wraps; the MSB is then the sign.
    // ------------------------------------------------------------------
    logic [15:0]   coll_vec;
    logic [15:0]   above_vec;
    logic [15:0]   wr_vec;
    logic [RW-1:0] wr_row [16];
    logic [CW-1:0] wr_col [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_mask
        localparam int BI = gi / 4;
        localparam int BJ = gi % 4;

        logic [YW:0]   m_row;
        logic [XW:0]   m_col;
        logic          row_neg;
        logic          row_ok;
        logic          col_ok;
        logic          cell_busy;
        logic [RW-1:0] r_idx;
        logic [CW-1:0] c_idx;

        assign m_row   = {cmd_y_reg[YW-1], cmd_y_reg} + (YW+1)'(BI);
        assign m_col   = {cmd_x_reg[XW-1], cmd_x_reg} + (XW+1)'(BJ);
        assign row_neg = m_row[YW];
        assign row_ok  = !row_neg && (m_row[YW-1:0] < YW'(ROWS));
        assign col_ok  = !m_col[XW] && (m_col[XW-1:0] < XW'(COLS));
        assign r_idx   = m_row[RW-1:0];
        assign c_idx   = m_col[CW-1:0];

        // Only looked at when both indices are inside the field.
        assign cell_busy = row_ok && col_ok && (field_reg[r_idx][c_idx] != '0);

        // Rows above the field are free, but a bad column always collides.
        assign coll_vec[gi]  = cmd_mask_reg[gi] &&
                               (!col_ok || (!row_neg && !row_ok) || cell_busy);
        assign above_vec[gi] = cmd_mask_reg[gi] && row_neg;
        assign wr_vec[gi]    = cmd_mask_reg[gi] && row_ok && col_ok;
        assign wr_row[gi]    = r_idx;
        assign wr_col[gi]    = c_idx;
    end

    // ------------------------------------------------------------------
    // Row occupancy
    // ------------------------------------------------------------------
    logic [ROWS-1:0] row_full;
    logic            row0_any;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [COLS-1:0] occ;
        for (genvar gj = 0; gj < COLS; gj++) begin : g_cell
            assign occ[gj] = |field_reg[gi][gj];
        end
        assign row_full[gi] = &occ;
        if (gi == 0) begin : g_top
            assign row0_any = |occ;
        end
    end

    // Bottom-most full row: later (larger) indices overwrite earlier ones.
    logic          full_found;
    logic [RW-1:0] full_idx;

    always_comb begin
        full_found = 1'b0;
        full_idx   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_full[r]) begin
                full_found = 1'b1;
                full_idx   = RW'(r);
            end
        end
    end

    // Colour actually written by APPEND: 0 would read back as empty.
    logic [COLOR_W-1:0] app_color;
    assign app_color = (cmd_color_reg == '0) ? COLOR_W'(1) : cmd_color_reg;

    // Garbage hole column; falls back to column 0 if x is off the field.
    logic [CW-1:0] hole_col;
    assign hole_col = (!cmd_x_reg[XW-1] && (cmd_x_reg[XW-2:0] < (XW-1)'(COLS)))
                      ? cmd_x_reg[CW-1:0] : '0;

    // ------------------------------------------------------------------
    // Field update
    // ------------------------------------------------------------------
    always_comb begin
        field_next = field_reg;
        case (state_reg)
            CLEAR: begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        field_next[r][c] = '0;
                    end
                end
            end
            APPEND: begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        for (int k = 0; k < 16; k++) begin
                            if (wr_vec[k] && (wr_row[k] == RW'(r)) && (wr_col[k] == CW'(c))) begin
                                field_next[r][c] = app_color;
                            end
                        end
                    end
                end
            end
            SCAN: begin
                // Everything above the removed row drops by one; rows below stay.
                if (full_found) begin
                    for (int r = ROWS - 1; r >= 1; r--) begin
                        if (RW'(r) <= full_idx) begin
                            for (int c = 0; c < COLS; c++) begin
                                field_next[r][c] = field_reg[r-1][c];
                            end
                        end
                    end
                    for (int c = 0; c < COLS; c++) begin
                        field_next[0][c] = '0;
                    end
                end
            end
            GARB: begin
                if (GARB_EN) begin
                    for (int r = 0; r < ROWS - 1; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            field_next[r][c] = field_reg[r+1][c];
                        end
                    end
                    for (int c = 0; c < COLS; c++) begin
                        field_next[ROWS-1][c] = (CW'(c) == hole_col) ? '0
                                                : COLOR_W'(GARBAGE_COLOR);
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state and response values
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        lines_next        = lines_reg;
        topout_acc_next   = topout_acc_reg;
        resp_collide_next = resp_collide_reg;
        resp_lines_next   = resp_lines_reg;
        resp_topout_next  = resp_topout_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        2'd0:    state_next = CLEAR;
                        2'd1:    state_next = CHECK;
                        2'd2:    state_next = APPEND;
                        default: state_next = GARB;
                    endcase
                end
            end
            CLEAR: begin
                state_next        = RESP;
                resp_collide_next = 1'b0;
                resp_lines_next   = 3'd0;
                resp_topout_next  = 1'b0;
            end
            CHECK: begin
                state_next        = RESP;
                resp_collide_next = |coll_vec;
                resp_lines_next   = 3'd0;
                resp_topout_next  = 1'b0;
            end
            APPEND: begin
                state_next      = SCAN;
                lines_next      = 3'd0;
                topout_acc_next = |above_vec;
            end
            SCAN: begin
                if (full_found) begin
                    if (lines_reg != 3'd4) begin
                        lines_next = lines_reg + 3'd1;
                    end
                end else begin
                    // Field is final here, so row 0 reflects the settled stack.
                    state_next        = RESP;
                    resp_collide_next = 1'b0;
                    resp_lines_next   = lines_reg;
                    resp_topout_next  = topout_acc_reg || row0_any;
                end
            end
            GARB: begin
                state_next        = RESP;
                resp_collide_next = 1'b0;
                resp_lines_next   = 3'd0;
                resp_topout_next  = GARB_EN && row0_any;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_reg        <= IDLE;
            lines_reg        <= 3'd0;
            topout_acc_reg   <= 1'b0;
            resp_collide_reg <= 1'b0;
            resp_lines_reg   <= 3'd0;
            resp_topout_reg  <= 1'b0;
            cmd_mask_reg     <= '0;
            cmd_x_reg        <= '0;
            cmd_y_reg        <= '0;
            cmd_color_reg    <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    field_reg[r][c] <= '0;
                end
            end
        end else begin
            state_reg        <= state_next;
            lines_reg        <= lines_next;
            topout_acc_reg   <= topout_acc_next;
            resp_collide_reg <= resp_collide_next;
            resp_lines_reg   <= resp_lines_next;
            resp_topout_reg  <= resp_topout_next;
            field_reg        <= field_next;
            if (cmd_accept) begin
                cmd_mask_reg  <= blk_mask_i;
                cmd_x_reg     <= blk_x_i;
                cmd_y_reg     <= blk_y_i;
                cmd_color_reg <= blk_color_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flattened field output
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_out_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_out_col
            assign field_o[(gi*COLS+gj)*COLOR_W +: COLOR_W] = field_reg[gi][gj];
        end
    end

endmodule

// File: tb/tb_tetris_field_engine.sv
`timescale 1ns/1ps
module tb_tetris_field_engine;

    localparam int ROWS    = 20;
    localparam int COLS    = 10;
    localparam int COLOR_W = 3;
    localparam int GCOL    = 7;
    localparam int XW      = $clog2(COLS) + 2;
    localparam int YW      = $clog2(ROWS) + 2;
    localparam int FW      = ROWS * COLS * COLOR_W;

    logic               clk_i = 1'b0;
    logic               srst_n_i = 1'b0;
    logic               cmd_valid_i = 1'b0;
    logic               cmd_ready_o;
    logic [1:0]         cmd_op_i = '0;
    logic [15:0]        blk_mask_i = '0;
    logic [XW-1:0]      blk_x_i = '0;
    logic [YW-1:0]      blk_y_i = '0;
    logic [COLOR_W-1:0] blk_color_i = '0;
    logic               resp_valid_o;
    logic               resp_collide_o;
    logic [2:0]         resp_lines_o;
    logic               resp_topout_o;
    logic [FW-1:0]      field_o;

    tetris_field_engine dut (
        .clk_i          (clk_i),
        .srst_n_i       (srst_n_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .blk_mask_i     (blk_mask_i),
        .blk_x_i        (blk_x_i),
        .blk_y_i        (blk_y_i),
        .blk_color_i    (blk_color_i),
        .resp_valid_o   (resp_valid_o),
        .resp_collide_o (resp_collide_o),
        .resp_lines_o   (resp_lines_o),
        .resp_topout_o  (resp_topout_o),
        .field_o        (field_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [31:0]   acc;
        logic [31:0]   lat;
        logic          coll;
        logic [2:0]    lines;
        logic          top;
        logic [FW-1:0] fld;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int mdl [ROWS][COLS];

    task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [FW-1:0] model_pack();
        logic [FW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*COLOR_W +: COLOR_W] = COLOR_W'(mdl[r][c]);
        return v;
    endfunction

    task automatic model_zero();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mdl[r][c] = 0;
    endtask

    function automatic bit model_collide(input logic [15:0] m, input int x, input int y);
        bit hit;
        int r;
        int c;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (m[4*i+j]) begin
                    r = y + i;
                    c = x + j;
                    if (c < 0 || c >= COLS || r >= ROWS) hit = 1'b1;
                    else if (r >= 0 && mdl[r][c] != 0) hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    task automatic model_append(input logic [15:0] m, input int x, input int y, input int color,
                                output int removed, output bit top);
        int tmp [ROWS][COLS];
        int cw;
        int dst;
        int r;
        int c;
        bit full;
        cw  = (color == 0) ? 1 : color;
        top = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (m[4*i+j]) begin
                    r = y + i;
                    c = x + j;
                    if (r < 0) top = 1'b1;
                    else if (r < ROWS && c >= 0 && c < COLS) mdl[r][c] = cw;
                end
            end
        end
        // Keep non-full rows, packed towards the bottom.
        dst = ROWS - 1;
        removed = 0;
        for (int rr = ROWS - 1; rr >= 0; rr--) begin
            full = 1'b1;
            for (int cc = 0; cc < COLS; cc++) if (mdl[rr][cc] == 0) full = 1'b0;
            if (full) removed++;
            else begin
                for (int cc = 0; cc < COLS; cc++) tmp[dst][cc] = mdl[rr][cc];
                dst--;
            end
        end
        for (int rr = dst; rr >= 0; rr--)
            for (int cc = 0; cc < COLS; cc++) tmp[rr][cc] = 0;
        mdl = tmp;
        for (int cc = 0; cc < COLS; cc++) if (mdl[0][cc] != 0) top = 1'b1;
    endtask

    task automatic model_garbage(input int x, output bit top);
        int hole;
        top = 1'b0;
`ifdef TETRIS_FIELD_GARBAGE_ROW_EN
        for (int c = 0; c < COLS; c++) if (mdl[0][c] != 0) top = 1'b1;
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) mdl[r][c] = mdl[r+1][c];
        hole = (x >= 0 && x < COLS) ? x : 0;
        for (int c = 0; c < COLS; c++) mdl[ROWS-1][c] = (c == hole) ? 0 : GCOL;
`else
        hole = x;
`endif
    endtask

    // ---------------- driver ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("wait_ready", FW'(cmd_ready_o), FW'(1));
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] m, input int x, input int y, input int color);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        blk_mask_i  = m;
        blk_x_i     = XW'(x);
        blk_y_i     = YW'(y);
        blk_color_i = COLOR_W'(color);
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [15:0] m,
                         input int x, input int y, input int color);
        exp_t e;
        int   removed;
        bit   top;
        int   n;
        wait_idle();
        e = '0;
        e.lat = 2;
        case (op)
            2'd0: model_zero();
            2'd1: e.coll = model_collide(m, x, y);
            2'd2: begin
                model_append(m, x, y, color, removed, top);
                e.lat   = 32'(3 + removed);
                e.lines = (removed > 4) ? 3'd4 : 3'(removed);
                e.top   = top;
            end
            default: begin
                model_garbage(x, top);
                e.top = top;
            end
        endcase
        e.fld = model_pack();
        drive(op, m, x, y, color);
        e.acc = 32'(cyc);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        check_eq({tag, "_busy"}, FW'(cmd_ready_o), FW'(0));
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_eq({tag, "_resp_timeout"}, FW'(sb_q.size()), FW'(0));
            sb_q.delete();
            tag_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        exp_t  e;
        string t;
        if (srst_n_i && resp_valid_o) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_resp", FW'(resp_valid_o), FW'(0));
            end else begin
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                $display("resp %s lat=%0d coll=%0d lines=%0d top=%0d", t,
                         cyc - int'(e.acc), resp_collide_o, resp_lines_o, resp_topout_o);
                check_eq({t, "_lat"},     FW'(cyc - int'(e.acc)), FW'(e.lat));
                check_eq({t, "_collide"}, FW'(resp_collide_o),    FW'(e.coll));
                check_eq({t, "_lines"},   FW'(resp_lines_o),      FW'(e.lines));
                check_eq({t, "_topout"},  FW'(resp_topout_o),     FW'(e.top));
                check_eq({t, "_ready"},   FW'(cmd_ready_o),       FW'(0));
                check_eq({t, "_field"},   field_o,                e.fld);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int fill_x [9];
        fill_x = '{0, 1, 2, 3, 5, 6, 7, 8, 9};
        model_zero();

        srst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        srst_n_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst_ready",   FW'(cmd_ready_o),    FW'(1));
        check_eq("rst_valid",   FW'(resp_valid_o),   FW'(0));
        check_eq("rst_collide", FW'(resp_collide_o), FW'(0));
        check_eq("rst_lines",   FW'(resp_lines_o),   FW'(0));
        check_eq("rst_topout",  FW'(resp_topout_o),  FW'(0));
        check_eq("rst_field",   field_o,             model_pack());

        issue("clear0", 2'd0, 16'h0000, 0, 0, 0);

        // Horizontal I against the walls, above the top, below the floor.
        issue("chk_left",  2'd1, 16'h000F, -1,  0, 0);
        issue("chk_fit",   2'd1, 16'h000F,  6,  0, 0);
        issue("chk_right", 2'd1, 16'h000F,  7,  0, 0);
        issue("chk_above", 2'd1, 16'h000F,  0, -3, 0);
        issue("chk_floor", 2'd1, 16'h0011,  0, 19, 0);

        // Rows 16..19 full except column 4, then a vertical I closes all four.
        foreach (fill_x[k]) issue("fill4", 2'd2, 16'h1111, fill_x[k], 16, (k % 7));
        issue("chk_occupied", 2'd1, 16'h0001, 0, 16, 0);
        issue("tetris",       2'd2, 16'h1111, 4, 16, 5);
        @(negedge clk_i);
        check_eq("hold_lines", FW'(resp_lines_o), FW'(4));
        check_eq("hold_valid", FW'(resp_valid_o), FW'(0));

        // Rows 17 and 19 full except column 0, single cell in row 18.
        issue("clear1", 2'd0, 16'h0000, 0, 0, 0);
        issue("r19a", 2'd2, 16'h000F, 1, 19, 2);
        issue("r19b", 2'd2, 16'h000F, 5, 19, 3);
        issue("r19c", 2'd2, 16'h0001, 9, 19, 4);
        issue("r17a", 2'd2, 16'h000F, 1, 17, 6);
        issue("r17b", 2'd2, 16'h000F, 5, 17, 1);
        issue("r17c", 2'd2, 16'h0001, 9, 17, 2);
        issue("r18",  2'd2, 16'h0001, 3, 18, 6);
        issue("split2", 2'd2, 16'h0101, 0, 17, 3);
        check_eq("split2_row19_col3", FW'(field_o[((19*COLS)+3)*COLOR_W +: COLOR_W]), FW'(6));

        // Top-out: block row 2 lands on field row 0.
        issue("clear2", 2'd0, 16'h0000, 0, 0, 0);
        issue("topout_row0", 2'd2, 16'h0F00, 2, -2, 3);
        issue("topout_above", 2'd2, 16'h0011, 8, -1, 0);

        // Garbage (row 0 is non-empty at this point), then hole out of range.
        issue("garb_x3",  2'd3, 16'h0000,  3, 0, 0);
        issue("garb_x12", 2'd3, 16'h0000, 12, 0, 0);

        // Reset during the second SCAN cycle of a two-line clear.
        issue("clear3", 2'd0, 16'h0000, 0, 0, 0);
        issue("q19a", 2'd2, 16'h000F, 1, 19, 2);
        issue("q19b", 2'd2, 16'h000F, 5, 19, 2);
        issue("q19c", 2'd2, 16'h0001, 9, 19, 2);
        issue("q18a", 2'd2, 16'h000F, 1, 18, 4);
        issue("q18b", 2'd2, 16'h000F, 5, 18, 4);
        issue("q18c", 2'd2, 16'h0001, 9, 18, 4);
        wait_idle();
        drive(2'd2, 16'h0011, 0, 18, 5);
        @(posedge clk_i);
        @(negedge clk_i);            // T+1 APPEND
        cmd_valid_i = 1'b0;
        @(negedge clk_i);            // T+2 first SCAN
        @(negedge clk_i);            // T+3 second SCAN
        srst_n_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_scan_valid", FW'(resp_valid_o), FW'(0));
            @(negedge clk_i);
        end
        srst_n_i = 1'b1;
        model_zero();
        @(negedge clk_i);
        $display("reset during scan released at cycle %0d", cyc);
        check_eq("rst2_ready",  FW'(cmd_ready_o),   FW'(1));
        check_eq("rst2_valid",  FW'(resp_valid_o),  FW'(0));
        check_eq("rst2_lines",  FW'(resp_lines_o),  FW'(0));
        check_eq("rst2_field",  field_o,            model_pack());

        issue("post_rst_chk", 2'd1, 16'h0033, 4, 18, 0);
        issue("post_rst_app", 2'd2, 16'h0033, 4, 18, 0);

        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
